// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbitration logic.
package fifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester found scanning upward from
// the one after i_last_grant, wrapping modulo NUM_REQ.
module rr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int GW = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [GW-1:0]      i_last_grant,
   output logic [GW-1:0]      o_gnt_id,
   output logic               o_gnt_vld
);

   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_id  = '0;
      // Walk from the farthest offset down so the nearest requester is written last and wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         int idx;
         idx = (int'(i_last_grant) + k) % NUM_REQ;
         if (i_req[idx]) begin
            o_gnt_vld = 1'b1;
            o_gnt_id  = GW'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NUM_REQ requesters: round-robin grant held for a
// whole packet (capped at MAX_BURST beats), w_full back-pressure to the granted one only.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   localparam int GW = clog2(NUM_REQ)
) (
   input  logic                          w_clk,
   input  logic                          w_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          w_full,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         w_data,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy
);

   localparam int CW = clog2(MAX_BURST + 1);

   arb_state_e      r_state;
   logic [GW-1:0]   r_last_grant;
   logic [GW-1:0]   r_grant_id;
   logic [CW-1:0]   r_beat_cnt;

   logic [GW-1:0]         w_gnt_id;
   logic                  w_gnt_vld;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_release;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_gnt_id     (w_gnt_id),
      .o_gnt_vld    (w_gnt_vld)
   );

   // Only registered grant state and w_full reach req_ready; req_valid never does.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      req_ready   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == GW'(i)) begin
            w_sel_valid  = req_valid[i];
            w_sel_last   = req_last[i];
            w_sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            req_ready[i] = w_busy & ~w_full;
         end
      end
   end

   assign w_busy    = (r_state == BURST);
   assign w_accept  = w_busy & w_sel_valid & ~w_full;
   assign w_release = w_sel_last | (r_beat_cnt == CW'(MAX_BURST - 1));

   assign busy     = w_busy;
   assign grant_id = r_grant_id;
   assign w_en     = w_accept;
   assign w_data   = w_busy ? w_sel_data : '0;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= GW'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_beat_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_vld) begin
                  r_grant_id <= w_gnt_id;
                  r_beat_cnt <= '0;
                  r_state    <= BURST;
               end
            end
            BURST: begin
               // A MAX_BURST cut releases like a packet end; the remainder re-arbitrates.
               if (w_accept) begin
                  if (w_release) begin
                     r_last_grant <= r_grant_id;
                     r_beat_cnt   <= '0;
                     r_state      <= IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + CW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
